// File: rtl/baseline_detector_pkg.sv
// baseline_detector_pkg
//   Shared definitions for the baseline detector:
//     state_t    - persistence FSM state encoding (3 bits)
//     CNT_W      - width of the persistence counter
//     cmp_width  - common signed width holding both compare operands
//                  without truncation
package baseline_detector_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NORMAL  = 3'd1,
        PENDING = 3'd2,
        SEIZURE = 3'd3,
        RECOVER = 3'd4
    } state_t;

    localparam int CNT_W = 4;

    // lhs is feat_width+thr_frac bits; rhs is base_width+8 bits
    // (unsigned product). One extra bit keeps the unsigned rhs
    // positive once both are treated as signed.
    function automatic int cmp_width(input int feat_width,
                                     input int base_width,
                                     input int thr_frac);
        int lw;
        int rw;
        lw = feat_width + thr_frac;
        rw = base_width + 8;
        return ((lw > rw) ? lw : rw) + 1;
    endfunction

endpackage

// File: rtl/baseline_detector_scaled_compare.sv
// scaled_compare
//   Two-stage pipeline comparing a feature sample against the scaled
//   baseline: stage 1 registers lhs = din <<< thr_frac and
//   rhs = base * thr_num; stage 2 registers the strict compare.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   hold       freezes every register, including the valids
//   in_valid   accept din/base into stage 1 this cycle
//   din        signed feature sample
//   base       non-negative baseline (already clamped)
//   eval       stage-1 sample is being evaluated on the coming edge
//   hit        combinational compare result of the stage-1 sample
//   exceed     registered compare result, held between samples
//   out_valid  stage-2 valid (the caller gates it with hold)
module scaled_compare
    import baseline_detector_pkg::*;
#(
    parameter int feat_width = 25,
    parameter int base_width = 34,
    parameter int thr_num    = 12,
    parameter int thr_frac   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold,
    input  logic                         in_valid,
    input  logic signed [feat_width-1:0] din,
    input  logic        [base_width-1:0] base,
    output logic                         eval,
    output logic                         hit,
    output logic                         exceed,
    output logic                         out_valid
);

    localparam int LW = feat_width + thr_frac;
    localparam int RW = base_width + 8;
    localparam int CW = cmp_width(feat_width, base_width, thr_frac);
    localparam logic [7:0] THR = 8'(thr_num);

    logic signed [LW-1:0] lhs_w;
    logic        [RW-1:0] rhs_w;
    logic signed [CW-1:0] lhs_q;
    logic signed [CW-1:0] rhs_q;
    logic                 v1_q;

    // Sign-extend before shifting so no feature bit is lost.
    assign lhs_w = LW'(din) <<< thr_frac;
    assign rhs_w = RW'(base) * RW'(THR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lhs_q     <= '0;
            rhs_q     <= '0;
            v1_q      <= 1'b0;
            exceed    <= 1'b0;
            out_valid <= 1'b0;
        end else if (!hold) begin
            v1_q      <= in_valid;
            out_valid <= v1_q;
            if (in_valid) begin
                lhs_q <= CW'(lhs_w);
                // rhs is a non-negative product: zero-extend.
                rhs_q <= $signed(CW'(rhs_w));
            end
            if (v1_q) begin
                exceed <= hit;
            end
        end
    end

    // rhs >= 0, so a negative feature can never hit.
    assign hit  = lhs_q > rhs_q;
    assign eval = v1_q && !hold;

endmodule

// File: rtl/baseline_detector.sv
// baseline_detector
//   Latches the baseline, compares each feature sample against
//   baseline * thr_num / 2^thr_frac, and runs a persistence FSM with
//   hysteresis producing a seizure level and a one-cycle onset pulse.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           active-low enable: high freezes all state and
//                ignores strobes
//   din          signed feature sample, qualified by data_ready
//   base_din     signed baseline, qualified by base_valid
//   exceed       compare result of the most recent evaluated sample
//   seizure      level, high in SEIZURE and RECOVER
//   onset        one-cycle pulse when seizure rises
//   data_valid   one-cycle pulse per evaluated sample
//   state_dbg    current FSM state
//
// Strobe semantics: data_ready and base_valid are single-cycle valid
// strobes with no backpressure; a word is taken on the rising edge
// where its strobe is high and en is low, otherwise it is lost.
module baseline_detector
    import baseline_detector_pkg::*;
#(
    parameter int feat_width = 25,
    parameter int base_width = 34,
    parameter int thr_num    = 12,
    parameter int thr_frac   = 2,
    parameter int on_len     = 3,
    parameter int off_len    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [feat_width-1:0] din,
    input  logic                         data_ready,
    input  logic signed [base_width-1:0] base_din,
    input  logic                         base_valid,
    output logic                         exceed,
    output logic                         seizure,
    output logic                         onset,
    output logic                         data_valid,
    output logic [2:0]                   state_dbg
);

    localparam logic [CNT_W-1:0] ON_LEN_C  = CNT_W'(on_len);
    localparam logic [CNT_W-1:0] OFF_LEN_C = CNT_W'(off_len);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [base_width-1:0] base_q;
    logic                  have_base;
    logic                  accept;
    logic                  eval;
    logic                  hit;
    logic                  out_valid;
    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  onset_q;
    logic                  seiz_next;

    // have_base is the registered flag, so a sample arriving with the
    // very first base_valid is dropped, and a sample arriving with any
    // later base_valid uses the previous baseline.
    assign accept = data_ready && !en && have_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            have_base <= 1'b0;
        end else if (base_valid && !en) begin
            base_q    <= base_din[base_width-1] ? '0 : base_din;
            have_base <= 1'b1;
        end
    end

    scaled_compare #(
        .feat_width (feat_width),
        .base_width (base_width),
        .thr_num    (thr_num),
        .thr_frac   (thr_frac)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .hold      (en),
        .in_valid  (accept),
        .din       (din),
        .base      (base_q),
        .eval      (eval),
        .hit       (hit),
        .exceed    (exceed),
        .out_valid (out_valid)
    );

    // FSM advances on the same edge that moves the sample into stage 2,
    // so seizure/onset line up with that sample's data_valid.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (have_base) state_next = NORMAL;
            end
            NORMAL: begin
                if (eval && hit) begin
                    cnt_next   = CNT_ONE;
                    state_next = (ON_LEN_C <= CNT_ONE) ? SEIZURE : PENDING;
                end
            end
            PENDING: begin
                if (eval) begin
                    if (hit) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= ON_LEN_C) state_next = SEIZURE;
                    end else begin
                        cnt_next   = '0;
                        state_next = NORMAL;
                    end
                end
            end
            SEIZURE: begin
                if (eval && !hit) begin
                    cnt_next   = CNT_ONE;
                    state_next = (OFF_LEN_C <= CNT_ONE) ? NORMAL : RECOVER;
                end
            end
            RECOVER: begin
                if (eval) begin
                    if (hit) begin
                        cnt_next   = '0;
                        state_next = SEIZURE;
                    end else begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= OFF_LEN_C) begin
                            cnt_next   = '0;
                            state_next = NORMAL;
                        end
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign seiz_next = (state_next == SEIZURE) || (state_next == RECOVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            onset_q <= 1'b0;
        end else if (!en) begin
            state   <= state_next;
            cnt     <= cnt_next;
            onset_q <= seiz_next && !seizure;
        end
    end

    assign seizure    = (state == SEIZURE) || (state == RECOVER);
    // Stage-2 valid and onset are held while frozen; masking them keeps
    // each pulse visible for exactly one enabled cycle.
    assign onset      = onset_q && !en;
    assign data_valid = out_valid && !en;
    assign state_dbg  = state;

endmodule

// File: tb/tb_baseline_detector.sv
module tb_baseline_detector;
    import baseline_detector_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [24:0] din;
    logic               data_ready;
    logic signed [33:0] base_din;
    logic               base_valid;
    logic               exceed;
    logic               seizure;
    logic               onset;
    logic               data_valid;
    logic [2:0]         state_dbg;

    int tests    = 0;
    int failures = 0;

    baseline_detector dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .data_ready (data_ready),
        .base_din   (base_din),
        .base_valid (base_valid),
        .exceed     (exceed),
        .seizure    (seizure),
        .onset      (onset),
        .data_valid (data_valid),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    // exp = {data_valid, exceed, seizure, onset} observed in the cycle
    // whose inputs are rdy/din/bv/base.
    typedef struct {
        logic       rdy;
        int         din;
        logic       bv;
        longint     base;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rdy, input int d, input logic bv,
                                input longint b, input logic [3:0] e);
        vec_t v;
        v.rdy  = rdy;
        v.din  = d;
        v.bv   = bv;
        v.base = b;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input int d, input logic bv,
                         input longint b, input logic e);
        data_ready = rdy;
        din        = 25'(d);
        base_valid = bv;
        base_din   = 34'(b);
        en         = e;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({data_valid, exceed, seizure, onset});
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        check("reset_outs", outs(), 32'h0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;

        // no baseline yet: samples dropped
        for (int i = 0; i < 5; i++) add(1, 1000, 0, 0, 4'b0000);
        add(0, 0, 0, 0, 4'b0000);
        add(0, 0, 0, 0, 4'b0000);
        // base=100; 300 -> 1200 vs 1200 miss, 301 -> hit
        add(0, 0, 1, 100, 4'b0000);
        add(1, 300, 0, 0, 4'b0000);
        add(1, 301, 0, 0, 4'b0000);
        add(0, 0, 0, 0, 4'b1000);
        add(0, 0, 0, 0, 4'b1100);
        // clear PENDING, then 301 x3 -> seizure, then 0,0,0,301,0,0,0,0
        add(1, 0, 0, 0, 4'b0100);
        add(1, 301, 0, 0, 4'b0100);
        add(1, 301, 0, 0, 4'b1000);
        add(1, 301, 0, 0, 4'b1100);
        add(1, 0, 0, 0, 4'b1100);
        add(1, 0, 0, 0, 4'b1111);
        add(1, 0, 0, 0, 4'b1010);
        add(1, 301, 0, 0, 4'b1010);
        add(1, 0, 0, 0, 4'b1010);
        add(1, 0, 0, 0, 4'b1110);
        add(1, 0, 0, 0, 4'b1010);
        add(1, 0, 0, 0, 4'b1010);
        add(0, 0, 0, 0, 4'b1010);
        add(0, 0, 0, 0, 4'b1000);
        // 301,301,0,301 then 0: never seizure
        add(1, 301, 0, 0, 4'b0000);
        add(1, 301, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 4'b1100);
        add(1, 301, 0, 0, 4'b1100);
        add(1, 0, 0, 0, 4'b1000);
        add(0, 0, 0, 0, 4'b1100);
        add(0, 0, 0, 0, 4'b1000);
        // simultaneous base=50 with din=200: old base used
        add(1, 200, 1, 50, 4'b0000);
        add(1, 200, 0, 0, 4'b0000);
        add(0, 0, 0, 0, 4'b1000);
        add(0, 0, 0, 0, 4'b1100);
        // negative base clamps to 0; 0 vs 0 miss, 1 hit, -1 miss
        add(0, 0, 1, -5, 4'b0100);
        add(1, 0, 0, 0, 4'b0100);
        add(1, 1, 0, 0, 4'b0100);
        add(1, -1, 0, 0, 4'b1000);
        add(0, 0, 0, 0, 4'b1100);
        add(0, 0, 0, 0, 4'b1000);
        // extreme widths: max base, max / min feature
        add(0, 0, 1, 64'h1_FFFF_FFFF, 4'b0000);
        add(1, 16777215, 0, 0, 4'b0000);
        add(1, -16777216, 0, 0, 4'b0000);
        add(0, 0, 0, 0, 4'b1000);
        add(0, 0, 0, 0, 4'b1000);
        add(0, 0, 0, 0, 4'b0000);

        foreach (vecs[k]) begin
            drive(vecs[k].rdy, vecs[k].din, vecs[k].bv, vecs[k].base, 1'b0);
            #1;
            check($sformatf("vec[%0d]", k), outs(), 32'(vecs[k].exp));
            tick();
        end

        // ---- freeze with two samples in flight ----
        drive(0, 0, 1, 100, 0);       tick();
        drive(1, 301, 0, 0, 0);       tick();   // A
        drive(1, 0, 0, 0, 0);         tick();   // B
        for (int i = 0; i < 3; i++) begin
            drive(1, 301, 1, 0, 1);   // strobes ignored while frozen
            #1;
            check($sformatf("freeze_dv[%0d]", i), 32'(data_valid), 32'h0);
            tick();
        end
        drive(0, 0, 0, 0, 0); #1;
        check("release_a", 32'({data_valid, exceed}), 32'h3);
        tick();
        #1;
        check("release_b", 32'({data_valid, exceed}), 32'h2);
        tick();
        drive(1, 200, 0, 0, 0); #1;
        check("no_ghost0", 32'(data_valid), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0); #1;
        check("no_ghost1", 32'(data_valid), 32'h0);
        tick();
        #1;
        check("base_kept", 32'({data_valid, exceed}), 32'h2);
        tick();

        // ---- asynchronous reset in PENDING with a sample in flight ----
        drive(1, 301, 0, 0, 0); tick();
        tick();
        #1;
        check("pre_rst_pending", 32'(state_dbg), 32'(PENDING));
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        check("pre_rst_exceed", 32'(exceed), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outs", outs(), 32'h0);
        check("async_rst_state", 32'(state_dbg), 32'(IDLE));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 301, 0, 0, 0); #1;
            check($sformatf("post_rst_drop[%0d]", i), 32'(data_valid), 32'h0);
            tick();
        end
        drive(0, 0, 1, 100, 0); #1;
        check("post_rst_base", 32'(data_valid), 32'h0);
        tick();
        drive(1, 301, 0, 0, 0); #1;
        check("post_rst_first", 32'(data_valid), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0); #1;
        check("post_rst_lat1", 32'(data_valid), 32'h0);
        tick();
        #1;
        check("post_rst_out", 32'({data_valid, exceed}), 32'h3);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
